// File: rtl/xor_stream_framer_if.sv
// Beat and result handshake bundle for xor_stream_framer.
// master = upstream/harness side, slave = framer side.
interface xor_stream_framer_if #(
    parameter int unsigned MAX_LEN = 16
);
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    logic             in_valid;
    logic             in_ready;
    logic             in_u;
    logic             in_v;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic             out_parity;
    logic [LEN_W-1:0] out_ones;
    logic [LEN_W-1:0] out_len;
    logic             out_trunc;

    modport master (
        output in_valid, in_u, in_v, in_last, out_ready,
        input  in_ready, out_valid, out_parity, out_ones, out_len, out_trunc
    );

    modport slave (
        input  in_valid, in_u, in_v, in_last, out_ready,
        output in_ready, out_valid, out_parity, out_ones, out_len, out_trunc
    );
endinterface

// File: rtl/xor_stream_framer.sv
// Frames a stream of (u, v) beats and reports parity, ones count, length and
// truncation of w = u ^ v per frame through a valid/ready result port.
module xor_stream_framer #(
    parameter int unsigned MAX_LEN = 16
) (
    input logic               clk,
    input logic               rst,
    xor_stream_framer_if.slave bus
);
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] MaxLenW = LEN_W'(MAX_LEN);

    typedef enum logic {StAccum, StHold} state_e;

    state_e           state_q, state_d;
    logic             par_q, par_d;
    logic [LEN_W-1:0] ones_q, ones_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             res_par_q, res_par_d;
    logic [LEN_W-1:0] res_ones_q, res_ones_d;
    logic [LEN_W-1:0] res_len_q, res_len_d;
    logic             res_trunc_q, res_trunc_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic             w;
    logic             par_n;
    logic [LEN_W-1:0] ones_n;
    logic [LEN_W-1:0] len_n;

    always_comb begin
        w      = bus.in_u ^ bus.in_v;
        par_n  = par_q ^ w;
        ones_n = ones_q + LEN_W'(w);
        len_n  = len_q + LEN_W'(1);

        state_d     = state_q;
        par_d       = par_q;
        ones_d      = ones_q;
        len_d       = len_q;
        res_par_d   = res_par_q;
        res_ones_d  = res_ones_q;
        res_len_d   = res_len_q;
        res_trunc_d = res_trunc_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            StAccum: begin
                if (bus.in_valid && in_ready_q) begin
                    par_d  = par_n;
                    ones_d = ones_n;
                    len_d  = len_n;
                    if (bus.in_last || (len_n == MaxLenW)) begin
                        // Result takes the closing beat's contribution directly.
                        res_par_d   = par_n;
                        res_ones_d  = ones_n;
                        res_len_d   = len_n;
                        res_trunc_d = !bus.in_last;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = StHold;
                    end
                end
            end
            StHold: begin
                if (bus.out_ready) begin
                    par_d       = 1'b0;
                    ones_d      = '0;
                    len_d       = '0;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = StAccum;
                end
            end
            default: state_d = StAccum;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StAccum;
            par_q       <= 1'b0;
            ones_q      <= '0;
            len_q       <= '0;
            res_par_q   <= 1'b0;
            res_ones_q  <= '0;
            res_len_q   <= '0;
            res_trunc_q <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            par_q       <= par_d;
            ones_q      <= ones_d;
            len_q       <= len_d;
            res_par_q   <= res_par_d;
            res_ones_q  <= res_ones_d;
            res_len_q   <= res_len_d;
            res_trunc_q <= res_trunc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_parity = res_par_q;
    assign bus.out_ones   = res_ones_q;
    assign bus.out_len    = res_len_q;
    assign bus.out_trunc  = res_trunc_q;
endmodule

// File: tb/tb_xor_stream_framer.sv
// Scoreboard bench for xor_stream_framer: directed frames plus random frames
// checked against a frame-level reference computed from the gold XOR.
module tb_xor_stream_framer;
    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    typedef struct packed {
        logic             par;
        logic [LEN_W-1:0] ones;
        logic [LEN_W-1:0] len;
        logic             trunc;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    bit   rdy_rand = 1'b0;
    bit   rdy_force = 1'b1;

    xor_stream_framer_if #(.MAX_LEN(MAX_LEN)) bus ();

    xor_stream_framer #(.MAX_LEN(MAX_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // out_ready changes just after the rising edge so the negedge monitor sees it settled.
    always @(posedge clk) begin
        #1;
        bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
    end

    // Monitor: pops the scoreboard on each handshake and checks handshake invariants.
    logic             prev_hold = 1'b0;
    logic             prev_rst = 1'b1;
    res_t             prev_res;
    always @(negedge clk) begin
        res_t cur;
        res_t e;
        cur = '{par: bus.out_parity, ones: bus.out_ones, len: bus.out_len,
                trunc: bus.out_trunc};
        if (bus.in_ready && bus.out_valid) begin
            errors++;
            $display("FAIL ready_valid_excl: in_ready=1 and out_valid=1 (t=%0t)", $time);
        end
        if (prev_hold && !prev_rst && (!bus.out_valid || cur != prev_res)) begin
            errors++;
            $display("FAIL hold_stable: got %h valid=%0d, expected %h valid=1 (t=%0t)",
                     cur, bus.out_valid, prev_res, $time);
        end
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got %h, expected none (t=%0t)", cur, $time);
            end else begin
                e = exp_q.pop_front();
                chk("out_parity", 32'(bus.out_parity), 32'(e.par));
                chk("out_ones", 32'(bus.out_ones), 32'(e.ones));
                chk("out_len", 32'(bus.out_len), 32'(e.len));
                chk("out_trunc", 32'(bus.out_trunc), 32'(e.trunc));
            end
        end
        prev_hold = bus.out_valid && !bus.out_ready;
        prev_rst  = rst;
        prev_res  = cur;
    end

    task automatic push_exp(input int par, input int ones, input int len, input int trunc);
        res_t e;
        e.par   = 1'(par);
        e.ones  = LEN_W'(ones);
        e.len   = LEN_W'(len);
        e.trunc = 1'(trunc);
        exp_q.push_back(e);
    endtask

    // Presents a beat and returns just after the edge on which it is accepted.
    task automatic send_beat(input logic u, input logic v, input logic last,
                             output int waits);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_u     = u;
        bus.in_v     = v;
        bus.in_last  = last;
        waits = 0;
        while (!bus.in_ready && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (!bus.in_ready) begin
            errors++;
            $display("FAIL accept_timeout: got no in_ready, expected one within 200 cycles");
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic beat(input logic u, input logic v, input logic last);
        int w;
        send_beat(u, v, last, w);
    endtask

    // Idle cycle with garbage on the data lines; must be ignored.
    task automatic gap();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_u     = 1'($urandom_range(0, 1));
        bus.in_v     = 1'($urandom_range(0, 1));
        bus.in_last  = 1'($urandom_range(0, 1));
    endtask

    task automatic rand_frame();
        int n;
        bit lst;
        bit uu[MAX_LEN];
        bit vv[MAX_LEN];
        int ones;
        n   = ($urandom_range(0, 3) == 0) ? MAX_LEN : $urandom_range(1, MAX_LEN);
        lst = (n < MAX_LEN) ? 1'b1 : 1'($urandom_range(0, 1));
        ones = 0;
        for (int i = 0; i < n; i++) begin
            uu[i] = 1'($urandom_range(0, 1));
            vv[i] = 1'($urandom_range(0, 1));
            if (uu[i] != vv[i]) ones++;
        end
        push_exp(ones % 2, ones, n, lst ? 0 : 1);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) gap();
            beat(uu[i], vv[i], lst && (i == n - 1));
        end
    endtask

    task automatic wait_ready_on();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int waits;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_u      = 1'b0;
        bus.in_v      = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 32'(bus.in_ready), 1);
        chk("reset_out_valid", 32'(bus.out_valid), 0);
        chk("reset_out_parity", 32'(bus.out_parity), 0);
        chk("reset_out_ones", 32'(bus.out_ones), 0);
        chk("reset_out_len", 32'(bus.out_len), 0);
        chk("reset_out_trunc", 32'(bus.out_trunc), 0);

        // Four-beat frame and its latency.
        push_exp(0, 2, 4, 0);
        beat(1'b1, 1'b0, 1'b0);
        beat(1'b1, 1'b1, 1'b0);
        beat(1'b0, 1'b1, 1'b0);
        beat(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("lat_out_valid", 32'(bus.out_valid), 1);
        chk("lat_in_ready", 32'(bus.in_ready), 0);
        @(negedge clk);
        chk("bubble_in_ready", 32'(bus.in_ready), 1);
        chk("bubble_out_valid", 32'(bus.out_valid), 0);

        // 20 beats: truncated frame of MAX_LEN, then the remaining 4 closed by last.
        push_exp(0, 16, 16, 1);
        push_exp(0, 4, 4, 0);
        for (int i = 0; i < 20; i++) beat(1'b1, 1'b0, i == 19);

        // Single-beat frame.
        push_exp(1, 1, 1, 0);
        beat(1'b1, 1'b0, 1'b1);

        // last on beat MAX_LEN is not a truncation.
        push_exp(0, 16, 16, 0);
        for (int i = 0; i < 16; i++) beat(1'b0, 1'b1, i == 15);

        // Backpressure with a held upstream beat.
        rdy_force = 1'b0;
        wait_ready_on();
        push_exp(1, 1, 2, 0);
        beat(1'b1, 1'b1, 1'b0);
        beat(1'b1, 1'b0, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_u     = 1'b0;
        bus.in_v     = 1'b1;
        bus.in_last  = 1'b1;
        push_exp(1, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(bus.in_ready), 0);
            chk("bp_out_valid", 32'(bus.out_valid), 1);
        end
        rdy_force = 1'b1;
        waits = 0;
        while (!bus.in_ready && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        chk("bp_release_wait", waits, 2);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;

        // Reset mid-frame discards the partial frame.
        beat(1'b1, 1'b0, 1'b0);
        beat(1'b1, 1'b0, 1'b0);
        beat(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_out_valid", 32'(bus.out_valid), 0);
        chk("rst_mid_in_ready", 32'(bus.in_ready), 1);
        push_exp(1, 1, 1, 0);
        beat(1'b0, 1'b1, 1'b1);

        // Reset during HOLD drops the pending result.
        @(negedge clk);
        rdy_force = 1'b0;
        wait_ready_on();
        push_exp(0, 0, 1, 0);
        beat(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("hold_pending", 32'(bus.out_valid), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_hold_out_valid", 32'(bus.out_valid), 0);
        chk("rst_hold_in_ready", 32'(bus.in_ready), 1);
        void'(exp_q.pop_back());
        rdy_force = 1'b1;
        wait_ready_on();

        // Random frames with random backpressure and idle gaps.
        rdy_rand = 1'b1;
        for (int f = 0; f < 1000; f++) rand_frame();
        rdy_rand  = 1'b0;
        rdy_force = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
